// File: rtl/kid_motion.sv
// Kid position/physics controller.
// Each frame tick walks, jumps and applies gravity as a series of 1-pixel
// sub-steps, one per clock. Every sub-step is gated by the collision flag for
// its direction, so the kid stops exactly on a boundary.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   tick            one-cycle frame strobe
//   respawn         one-cycle pulse, return to spawn (beats tick)
//   btn_left/right  walk buttons (level)
//   btn_jump        jump button (level, edge-detected per tick)
//   is_collide[3:0] top / bottom(grounded) / left / right blocked flags
//   kid_t/b/l/r     bounding box (b and r derived combinationally)
//   facing          0 = right, 1 = left
//   busy            high while a frame is being processed
//   fell_out        sticky death flag
//   frame_overrun   one-cycle pulse when a tick arrives while busy
//
// Optional feature: define KID_DOUBLE_JUMP_EN to allow one airborne jump.

module kid_motion #(
  parameter int unsigned KID_W      = 21,
  parameter int unsigned KID_H      = 21,
  parameter int unsigned SPAWN_L    = 40,
  parameter int unsigned SPAWN_T    = 362,
  parameter int unsigned WALK_SPEED = 3,
  parameter int unsigned JUMP_V     = 8,
  parameter int unsigned MAX_FALL   = 9,
  parameter int unsigned DEATH_Y    = 600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       respawn,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  input  logic [3:0] is_collide,
  output logic [9:0] kid_t,
  output logic [9:0] kid_b,
  output logic [9:0] kid_l,
  output logic [9:0] kid_r,
  output logic       facing,
  output logic       busy,
  output logic       fell_out,
  output logic       frame_overrun
);

  localparam int unsigned PW = 10;  // pixel coordinate width
  localparam int unsigned VW = 6;   // signed speed width
  localparam int unsigned CW = 4;   // step counter width

  localparam logic signed [VW-1:0] VY_JUMP = VW'(-int'(JUMP_V));
  localparam logic signed [VW-1:0] VY_MAX  = VW'(MAX_FALL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HMOVE,
    S_VMOVE
  } state_e;

  state_e                 state_q;
  logic [PW-1:0]          kid_l_q;
  logic [PW-1:0]          kid_t_q;
  logic signed [VW-1:0]   vy_q;
  logic [CW-1:0]          hcnt_q;
  logic [CW-1:0]          vcnt_q;
  logic                   dir_left_q;
  logic                   facing_q;
  logic                   busy_q;
  logic                   fell_out_q;
  logic                   overrun_q;
  logic                   jump_prev_q;
`ifdef KID_DOUBLE_JUMP_EN
  logic                   jumps_used_q;
  logic                   dbl_jump;
`endif

  logic                   jump_edge;
  logic                   grounded;
  logic                   blocked_h;
  logic signed [VW-1:0]   vy_new;
  logic [VW-1:0]          vy_abs;
  logic [CW-1:0]          vcnt_new;

  // Frame-start speed update and the vertical step count it implies.
  always_comb begin
    jump_edge = btn_jump & ~jump_prev_q;
    grounded  = is_collide[2];
`ifdef KID_DOUBLE_JUMP_EN
    dbl_jump  = 1'b0;
`endif
    vy_new    = vy_q;
    if (jump_edge && grounded) begin
      vy_new = VY_JUMP;
    end
`ifdef KID_DOUBLE_JUMP_EN
    else if (jump_edge && !jumps_used_q) begin
      vy_new   = VY_JUMP;
      dbl_jump = 1'b1;
    end
`endif
    else if (grounded && !vy_q[VW-1]) begin
      vy_new = '0;
    end else if (vy_q >= VY_MAX) begin
      vy_new = VY_MAX;
    end else begin
      vy_new = vy_q + VW'(1);
    end
    vy_abs   = vy_new[VW-1] ? VW'(-vy_new) : VW'(vy_new);
    // Clamp to the counter range; unreachable with sane speed parameters.
    vcnt_new = (vy_abs[VW-1:CW] != '0) ? '1 : vy_abs[CW-1:0];
  end

  // Left edge at x = 0 counts as a wall so kid_l cannot wrap.
  always_comb begin
    blocked_h = dir_left_q ? (is_collide[1] || (kid_l_q == '0)) : is_collide[0];
  end

  // Frame sequencer: IDLE -> HMOVE (walk steps) -> VMOVE (vertical steps).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      kid_l_q      <= PW'(SPAWN_L);
      kid_t_q      <= PW'(SPAWN_T);
      vy_q         <= '0;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      dir_left_q   <= 1'b0;
      facing_q     <= 1'b0;
      busy_q       <= 1'b0;
      fell_out_q   <= 1'b0;
      overrun_q    <= 1'b0;
      jump_prev_q  <= 1'b0;
`ifdef KID_DOUBLE_JUMP_EN
      jumps_used_q <= 1'b0;
`endif
    end else if (respawn) begin
      state_q      <= S_IDLE;
      kid_l_q      <= PW'(SPAWN_L);
      kid_t_q      <= PW'(SPAWN_T);
      vy_q         <= '0;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      dir_left_q   <= 1'b0;
      facing_q     <= 1'b0;
      busy_q       <= 1'b0;
      fell_out_q   <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef KID_DOUBLE_JUMP_EN
      jumps_used_q <= 1'b0;
`endif
    end else begin
      overrun_q <= tick && (state_q != S_IDLE);
      if (tick) begin
        jump_prev_q <= btn_jump;
      end
      if (kid_t_q >= PW'(DEATH_Y)) begin
        fell_out_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
`ifdef KID_DOUBLE_JUMP_EN
          if (grounded) begin
            jumps_used_q <= 1'b0;
          end
`endif
          if (tick && !fell_out_q) begin
            case ({btn_left, btn_right})
              2'b10: begin
                dir_left_q <= 1'b1;
                facing_q   <= 1'b1;
                hcnt_q     <= CW'(WALK_SPEED);
              end
              2'b01: begin
                dir_left_q <= 1'b0;
                facing_q   <= 1'b0;
                hcnt_q     <= CW'(WALK_SPEED);
              end
              default: hcnt_q <= '0;
            endcase
            vy_q    <= vy_new;
            vcnt_q  <= vcnt_new;
`ifdef KID_DOUBLE_JUMP_EN
            if (dbl_jump) begin
              jumps_used_q <= 1'b1;
            end
`endif
            state_q <= S_HMOVE;
            busy_q  <= 1'b1;
          end
        end

        S_HMOVE: begin
          if (hcnt_q == '0) begin
            state_q <= S_VMOVE;
          end else if (blocked_h) begin
            hcnt_q <= '0;
          end else begin
            kid_l_q <= dir_left_q ? (kid_l_q - PW'(1)) : (kid_l_q + PW'(1));
            hcnt_q  <= hcnt_q - CW'(1);
          end
        end

        S_VMOVE: begin
          if (vcnt_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (vy_q[VW-1]) begin
            // Moving up: ceiling kills the remaining rise.
            if (is_collide[3]) begin
              vy_q   <= '0;
              vcnt_q <= '0;
            end else begin
              if (kid_t_q != '0) begin
                kid_t_q <= kid_t_q - PW'(1);
              end
              vcnt_q <= vcnt_q - CW'(1);
            end
          end else begin
            // Moving down: floor kills the remaining fall.
            if (is_collide[2]) begin
              vy_q   <= '0;
              vcnt_q <= '0;
            end else begin
              if (kid_t_q != '1) begin
                kid_t_q <= kid_t_q + PW'(1);
              end
              vcnt_q <= vcnt_q - CW'(1);
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign kid_l         = kid_l_q;
  assign kid_t         = kid_t_q;
  assign kid_r         = kid_l_q + PW'(KID_W);
  assign kid_b         = kid_t_q + PW'(KID_H);
  assign facing        = facing_q;
  assign busy          = busy_q;
  assign fell_out      = fell_out_q;
  assign frame_overrun = overrun_q;

endmodule
